corr_accum: RTL and testbench
=============================

CORR_ACCUM -- requirements
Module: corr_accum

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter in_bits, default 8: signed width of each input I/Q component.
REQ-003 Parameter length, default 4: accepted sample pairs per accumulation frame, legal range 1 to 65535.
REQ-004 Localparam acc_bits SHALL equal 2*in_bits+1+clog2(length), with clog2(1)=0: output component width.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 m_axis_tvalid  in  1  upstream sample pair valid.
REQ-008 s_axis_tready  out  1  block can accept a sample pair.
REQ-009 xi, xq  in  in_bits each  signed reference sample I/Q.
REQ-010 yi, yq  in  in_bits each  signed shifted sample I/Q.
REQ-011 m_axis_tready  in  1  downstream arg-max stage can accept a result.
REQ-012 s_axis_tvalid  out  1  correlation result valid.
REQ-013 out_i, out_q  out  acc_bits each  signed accumulated correlation I/Q, feeding the arg-max xi/xq inputs.

Function
REQ-014 A sample pair SHALL be accepted on a rising edge where m_axis_tvalid and s_axis_tready are both 1.
REQ-015 On acceptance, the block SHALL register the full-precision products pr=xi*yi+xq*yq and pi=xq*yi-xi*yq, each 2*in_bits+1 bits signed (x times conj(y)).
REQ-016 On the edge after a product register load, the block SHALL sign-extend the registered products and add them into acc_i/acc_q (acc_bits), with no truncation, rounding or saturation.
REQ-017 The state machine SHALL have three states: ACCUM (s_axis_tready=1), DRAIN (s_axis_tready=0, one cycle), OUT (s_axis_tready=0, s_axis_tvalid=1).
REQ-018 In ACCUM, a sample counter SHALL count accepted pairs; cycles with m_axis_tvalid=0 SHALL change no state, counter, accumulator or output.
REQ-019 ACCUM->DRAIN SHALL occur on the edge accepting the length-th pair; the counter SHALL clear on that edge.
REQ-020 DRAIN->OUT SHALL occur on the next edge, while the final product is added to the accumulator on that same edge.
REQ-021 On entering OUT, out_i/out_q SHALL load the final accumulator sum.
REQ-022 Result latency: s_axis_tvalid SHALL rise at the 2nd rising edge after the edge accepting the length-th pair.
REQ-023 In OUT, out_i/out_q and s_axis_tvalid SHALL hold stable until an edge where m_axis_tready=1.
REQ-024 On that edge the result SHALL transfer, the accumulators SHALL clear and the state SHALL return to ACCUM; a transfer on the first OUT cycle is legal.
REQ-025 When length=1, every accepted pair SHALL form a complete frame with identical latency.
REQ-026 Frames SHALL be independent: no accumulator residue SHALL carry over between frames.

Reset
REQ-027 When reset=1 at a rising edge, the block SHALL enter ACCUM and clear the counter, product registers, accumulators and out_i/out_q to 0.
REQ-028 Reset SHALL set s_axis_tvalid=0 and s_axis_tready=1 from the following cycle.
REQ-029 Reset SHALL take priority over acceptance and transfer in the same cycle.
REQ-030 Reset asserted mid-frame or in OUT SHALL discard the partial or pending result, with no output transfer.

Verification (in_bits=8, length=4)
REQ-031 Scenario: 4 pairs x=(1,0), y=(1,0) back-to-back, m_axis_tready=1 -> out=(4,0), s_axis_tvalid high exactly 1 cycle, 2 edges after the 4th acceptance.
REQ-032 Scenario: 4 pairs x=(0,1), y=(1,0) -> out=(0,4); then 4 pairs x=(3,-2), y=(1,1) -> out=(4,-20), with no carry-over from the first frame.
REQ-033 Scenario: 4 pairs x=(-128,-128), y=(-128,-128) -> out=(131072,0) with acc_bits=19 and no overflow.
REQ-034 Scenario: m_axis_tvalid toggling 1,0,0,1,0,1,1 -> exactly 4 acceptances, result equals the 4-sample sum, idle cycles ignored.
REQ-035 Scenario: m_axis_tready=0 for 5 cycles after s_axis_tvalid rises -> outputs stable and s_axis_tready=0 for all 5 cycles, no sample absorbed even with m_axis_tvalid=1; transfer on the first ready cycle.
REQ-036 Scenario: reset pulse after 2 of 4 samples -> all outputs 0; the next 4 pairs x=(1,0), y=(1,0) -> out=(4,0).

Source files
------------

// File: rtl/corr_accum.sv
// corr_accum: complex correlation accumulator.
// Accepts `length` I/Q sample pairs. For each pair it registers the
// full-precision product x * conj(y), sums the products over the frame
// and presents the total to a downstream arg-max stage through a
// valid/ready handshake.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   m_axis_tvalid  upstream sample pair valid
//   s_axis_tready  block can accept a sample pair (registered)
//   xi, xq         signed reference sample I/Q
//   yi, yq         signed shifted sample I/Q
//   m_axis_tready  downstream can accept a result
//   s_axis_tvalid  correlation result valid (registered)
//   out_i, out_q   signed accumulated correlation I/Q (registered)
module corr_accum #(
  parameter int unsigned in_bits = 8,
  parameter int unsigned length  = 4,
  localparam int unsigned acc_bits = 2 * in_bits + 1 + $clog2(length)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       m_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic signed [in_bits-1:0]  xi,
  input  logic signed [in_bits-1:0]  xq,
  input  logic signed [in_bits-1:0]  yi,
  input  logic signed [in_bits-1:0]  yq,
  input  logic                       m_axis_tready,
  output logic                       s_axis_tvalid,
  output logic signed [acc_bits-1:0] out_i,
  output logic signed [acc_bits-1:0] out_q
);

  localparam int unsigned mul_bits  = 2 * in_bits;
  localparam int unsigned prod_bits = 2 * in_bits + 1;
  localparam int unsigned cnt_bits  = (length > 1) ? $clog2(length) : 1;
  localparam logic [cnt_bits-1:0] cnt_last = cnt_bits'(length - 1);

  localparam logic [1:0] st_accum = 2'd0;
  localparam logic [1:0] st_drain = 2'd1;
  localparam logic [1:0] st_out   = 2'd2;

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [cnt_bits-1:0] cnt;
  logic [cnt_bits-1:0] cnt_next;
  logic                accept_c;
  logic                xfer_c;

  logic signed [mul_bits-1:0]  m_ii;
  logic signed [mul_bits-1:0]  m_qq;
  logic signed [mul_bits-1:0]  m_qi;
  logic signed [mul_bits-1:0]  m_iq;
  logic signed [prod_bits-1:0] pr_c;
  logic signed [prod_bits-1:0] pi_c;

  logic signed [prod_bits-1:0] prod_i;
  logic signed [prod_bits-1:0] prod_q;
  logic                        prod_valid;
  logic signed [acc_bits-1:0]  acc_i;
  logic signed [acc_bits-1:0]  acc_q;
  logic signed [acc_bits-1:0]  acc_sum_i_c;
  logic signed [acc_bits-1:0]  acc_sum_q_c;

  // Full-precision x * conj(y); operands widened first so no bits are lost.
  assign m_ii = mul_bits'(xi) * mul_bits'(yi);
  assign m_qq = mul_bits'(xq) * mul_bits'(yq);
  assign m_qi = mul_bits'(xq) * mul_bits'(yi);
  assign m_iq = mul_bits'(xi) * mul_bits'(yq);
  assign pr_c = prod_bits'(m_ii) + prod_bits'(m_qq);
  assign pi_c = prod_bits'(m_qi) - prod_bits'(m_iq);

  // Running sum including the pending product. Out loads it on the DRAIN
  // edge, so the final product lands in out_* on the same edge it reaches
  // the accumulator.
  always_comb begin
    acc_sum_i_c = acc_i;
    acc_sum_q_c = acc_q;
    if (prod_valid) begin
      acc_sum_i_c = acc_i + acc_bits'(prod_i);
      acc_sum_q_c = acc_q + acc_bits'(prod_q);
    end
  end

  // Next-state, counter and handshake decode.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept_c   = 1'b0;
    xfer_c     = 1'b0;
    case (state)
      st_accum: begin
        if (m_axis_tvalid) begin
          accept_c = 1'b1;
          if (cnt == cnt_last) begin
            cnt_next   = '0;
            state_next = st_drain;
          end else begin
            cnt_next = cnt + cnt_bits'(1);
          end
        end
      end
      st_drain: state_next = st_out;
      st_out: begin
        if (m_axis_tready) begin
          xfer_c     = 1'b1;
          state_next = st_accum;
        end
      end
      default: state_next = st_accum;
    endcase
  end

  // State, counter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= st_accum;
      cnt           <= '0;
      s_axis_tready <= 1'b1;
      s_axis_tvalid <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      s_axis_tready <= (state_next == st_accum);
      s_axis_tvalid <= (state_next == st_out);
    end
  end

  // Product pipeline, accumulators and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_i     <= '0;
      prod_q     <= '0;
      prod_valid <= 1'b0;
      acc_i      <= '0;
      acc_q      <= '0;
      out_i      <= '0;
      out_q      <= '0;
    end else begin
      prod_valid <= accept_c;
      if (accept_c) begin
        prod_i <= pr_c;
        prod_q <= pi_c;
      end
      // A transfer only happens in OUT, where no product is pending.
      if (xfer_c) begin
        acc_i <= '0;
        acc_q <= '0;
      end else if (prod_valid) begin
        acc_i <= acc_sum_i_c;
        acc_q <= acc_sum_q_c;
      end
      if (state == st_drain) begin
        out_i <= acc_sum_i_c;
        out_q <= acc_sum_q_c;
      end
    end
  end

endmodule

// File: tb/tb_corr_accum.sv
// tb_corr_accum: scoreboard bench for corr_accum (in_bits=8, length=4).
// Expected frame sums are pushed when pairs are driven; the monitor pops
// and compares them whenever a result transfers.
module tb_corr_accum;

  localparam int IN  = 8;
  localparam int LEN = 4;
  localparam int ACC = 2 * IN + 1 + $clog2(LEN);

  typedef struct packed {
    logic signed [ACC-1:0] i;
    logic signed [ACC-1:0] q;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m_axis_tvalid = 1'b0;
  logic m_axis_tready = 1'b1;
  logic s_axis_tready;
  logic s_axis_tvalid;
  logic signed [IN-1:0] xi = '0;
  logic signed [IN-1:0] xq = '0;
  logic signed [IN-1:0] yi = '0;
  logic signed [IN-1:0] yq = '0;
  logic signed [ACC-1:0] out_i;
  logic signed [ACC-1:0] out_q;

  res_t sbq[$];
  int checks = 0;
  int errors = 0;
  int xfers = 0;
  int mi = 0;
  int mq = 0;

  corr_accum #(.in_bits(IN), .length(LEN)) dut (
    .clk(clk), .reset(reset),
    .m_axis_tvalid(m_axis_tvalid), .s_axis_tready(s_axis_tready),
    .xi(xi), .xq(xq), .yi(yi), .yq(yq),
    .m_axis_tready(m_axis_tready), .s_axis_tvalid(s_axis_tvalid),
    .out_i(out_i), .out_q(out_q)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: a result transfers on the next edge when valid && ready.
  always @(negedge clk) begin
    res_t e;
    if (!reset && s_axis_tvalid && m_axis_tready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got (%0d,%0d) required no result", out_i, out_q);
      end else begin
        e = sbq.pop_front();
        if (out_i !== e.i || out_q !== e.q) begin
          errors++;
          $display("FAIL result got (%0d,%0d) required (%0d,%0d)", out_i, out_q, e.i, e.q);
        end
      end
      xfers++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair and hold it until accepted; adds x*conj(y) to the model.
  task automatic send_pair(input int a, input int b, input int c, input int d);
    int n;
    bit took;
    n = 0;
    took = 1'b0;
    xi = IN'(a); xq = IN'(b); yi = IN'(c); yq = IN'(d);
    m_axis_tvalid = 1'b1;
    while (!took && n < 20) begin
      took = s_axis_tready;
      tick();
      n++;
    end
    if (!took) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got no acceptance required acceptance within 20 cycles");
    end
    mi += a * c + b * d;
    mq += b * c - a * d;
  endtask

  task automatic push_frame();
    res_t e;
    e.i = ACC'(mi);
    e.q = ACC'(mq);
    sbq.push_back(e);
    mi = 0;
    mq = 0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got %0d results outstanding required 0", name, sbq.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (s_axis_tready !== 1'b1 || s_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs got ready=%b valid=%b required ready=1 valid=0", s_axis_tready, s_axis_tvalid);
    end
    checks++;
    if (out_i !== '0 || out_q !== '0) begin
      errors++;
      $display("FAIL reset_out got (%0d,%0d) required (0,0)", out_i, out_q);
    end
    reset = 1'b0;
  endtask

  // Four unit pairs, ready held high: one drain cycle, one valid cycle.
  task automatic test_basic();
    int x0;
    m_axis_tready = 1'b1;
    for (int k = 0; k < LEN; k++) send_pair(1, 0, 1, 0);
    m_axis_tvalid = 1'b0;
    push_frame();
    x0 = xfers;
    checks++;
    if (s_axis_tready !== 1'b0 || s_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain got ready=%b valid=%b required ready=0 valid=0", s_axis_tready, s_axis_tvalid);
    end
    tick();
    checks++;
    if (s_axis_tvalid !== 1'b1 || out_i !== ACC'(4) || out_q !== ACC'(0)) begin
      errors++;
      $display("FAIL basic_out got valid=%b (%0d,%0d) required valid=1 (4,0)", s_axis_tvalid, out_i, out_q);
    end
    tick();
    checks++;
    if (s_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1 || xfers != x0 + 1) begin
      errors++;
      $display("FAIL basic_one_cycle got valid=%b ready=%b xfers=%0d required valid=0 ready=1 xfers=%0d",
               s_axis_tvalid, s_axis_tready, xfers, x0 + 1);
    end
  endtask

  // Two frames with the source always valid; the second must not see residue.
  task automatic test_back_to_back();
    int x0;
    x0 = xfers;
    for (int k = 0; k < LEN; k++) send_pair(0, 1, 1, 0);
    push_frame();
    for (int k = 0; k < LEN; k++) send_pair(3, -2, 1, 1);
    push_frame();
    m_axis_tvalid = 1'b0;
    wait_idle("back_to_back");
    checks++;
    if (xfers != x0 + 2) begin
      errors++;
      $display("FAIL b2b_count got %0d transfers required %0d", xfers - x0, 2);
    end
  endtask

  task automatic test_max();
    for (int k = 0; k < LEN; k++) send_pair(-128, -128, -128, -128);
    m_axis_tvalid = 1'b0;
    push_frame();
    wait_idle("max");
  endtask

  // Valid pattern 1,0,0,1,0,1,1 with junk data on idle cycles.
  task automatic test_gaps();
    int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    int smp[4][4] = '{'{2, -3, 5, 7}, '{-1, 4, -6, 2}, '{7, 7, -8, 1}, '{-5, 0, 3, -4}};
    int j;
    j = 0;
    for (int k = 0; k < 7; k++) begin
      if (pat[k] != 0) begin
        send_pair(smp[j][0], smp[j][1], smp[j][2], smp[j][3]);
        j++;
      end else begin
        m_axis_tvalid = 1'b0;
        xi = 8'sd127; xq = -8'sd99; yi = 8'sd55; yq = -8'sd128;
        tick();
      end
    end
    m_axis_tvalid = 1'b0;
    checks++;
    if (s_axis_tready !== 1'b0 || s_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL gaps_drain got ready=%b valid=%b required ready=0 valid=0", s_axis_tready, s_axis_tvalid);
    end
    push_frame();
    wait_idle("gaps");
  endtask

  // Downstream stalls five cycles while upstream keeps offering junk.
  task automatic test_backpressure();
    int x0;
    m_axis_tready = 1'b0;
    for (int k = 0; k < LEN; k++) send_pair(1, 2, 3, 4);
    m_axis_tvalid = 1'b0;
    push_frame();
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (s_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b0 || out_i !== ACC'(44) || out_q !== ACC'(8)) begin
        errors++;
        $display("FAIL stall_%0d got valid=%b ready=%b (%0d,%0d) required valid=1 ready=0 (44,8)",
                 c, s_axis_tvalid, s_axis_tready, out_i, out_q);
      end
      m_axis_tvalid = 1'b1;
      xi = -8'sd7; xq = 8'sd9; yi = 8'sd100; yq = 8'sd3;
      tick();
    end
    m_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    x0 = xfers;
    tick();
    checks++;
    if (s_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1 || xfers != x0 + 1) begin
      errors++;
      $display("FAIL stall_release got valid=%b ready=%b xfers=%0d required valid=0 ready=1 xfers=%0d",
               s_axis_tvalid, s_axis_tready, xfers, x0 + 1);
    end
    for (int k = 0; k < LEN; k++) send_pair(1, 0, 1, 0);
    m_axis_tvalid = 1'b0;
    push_frame();
    wait_idle("after_stall");
  endtask

  // Reset mid-frame and in OUT (with ready high): nothing may transfer.
  task automatic test_reset_mid();
    int x0;
    m_axis_tready = 1'b1;
    send_pair(5, 5, 5, 5);
    send_pair(5, 5, 5, 5);
    m_axis_tvalid = 1'b0;
    mi = 0; mq = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (out_i !== '0 || out_q !== '0 || s_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid got (%0d,%0d) valid=%b ready=%b required (0,0) valid=0 ready=1",
               out_i, out_q, s_axis_tvalid, s_axis_tready);
    end
    for (int k = 0; k < LEN; k++) send_pair(1, 0, 1, 0);
    m_axis_tvalid = 1'b0;
    push_frame();
    wait_idle("reset_mid");

    m_axis_tready = 1'b0;
    for (int k = 0; k < LEN; k++) send_pair(9, 9, 9, 9);
    m_axis_tvalid = 1'b0;
    mi = 0; mq = 0;
    tick();
    checks++;
    if (s_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL reset_out_pre got valid=%b required 1", s_axis_tvalid);
    end
    x0 = xfers;
    reset = 1'b1;
    m_axis_tready = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (s_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1 || out_i !== '0 || out_q !== '0 || xfers != x0) begin
      errors++;
      $display("FAIL reset_in_out got valid=%b ready=%b (%0d,%0d) xfers=%0d required valid=0 ready=1 (0,0) xfers=%0d",
               s_axis_tvalid, s_axis_tready, out_i, out_q, xfers, x0);
    end
    for (int k = 0; k < LEN; k++) send_pair(1, 0, 1, 0);
    m_axis_tvalid = 1'b0;
    push_frame();
    wait_idle("after_reset_out");
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_max();
    test_gaps();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
